// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   UART_DATA_W          : width of one received character
//   UART_RX_DEPTH_DEF    : default receive FIFO depth
//   UART_RX_TIMEOUT_DEF  : default idle-timeout length in clk cycles
//   IRQ_*_BIT            : interrupt-source bit positions in the bus status register
package uart_pkg;

  localparam int unsigned UART_DATA_W         = 8;
  localparam int unsigned UART_RX_DEPTH_DEF   = 8;
  localparam int unsigned UART_RX_TIMEOUT_DEF = 4096;

  localparam int unsigned IRQ_THR_BIT = 0;
  localparam int unsigned IRQ_TMO_BIT = 1;
  localparam int unsigned IRQ_OVR_BIT = 2;
  localparam int unsigned IRQ_SRC_W   = 3;

  typedef logic [IRQ_SRC_W-1:0] irq_src_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received bytes.
//   clk, RSTn : clock, asynchronous active-low reset
//   push, din : write request and data (ignored when full unless popping)
//   pop       : read request (ignored when empty)
//   dout      : current head, 0 when empty
//   count     : fill level; full/empty are derived from it
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [UART_DATA_W-1:0]   din,
  output logic [UART_DATA_W-1:0]   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale contents are never visible because dout is
  // masked by empty and full/empty come from count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between the UART receiver and the CPU bus.
// Captures one byte per rx_done rising edge into a show-ahead FIFO and
// raises a registered level interrupt on fill threshold, idle timeout or
// overrun.
//   clk, RSTn          : clock, asynchronous active-low reset
//   rx_byte, rx_done   : receiver data and frame-complete level
//   rx_busy            : receiver mid-frame
//   thr                : fill threshold for irq, 0 disables that source
//   rd_en, clr_ovr     : pop strobe, overrun clear
//   rd_data, count     : FIFO head (0 when empty), fill level
//   empty, full        : fill status
//   overrun, timeout   : sticky drop flag, idle timeout flag
//   irq                : level interrupt
// Build option: define UART_RX_CTRL_TIMEOUT_EN to include the idle-timeout
// counter; otherwise timeout is tied low and TIMEOUT_CYC is unused.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = UART_RX_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC = UART_RX_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic [UART_DATA_W-1:0] rx_byte,
  input  logic                   rx_done,
  input  logic                   rx_busy,
  input  logic [$clog2(DEPTH):0] thr,
  input  logic                   rd_en,
  input  logic                   clr_ovr,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun,
  output logic                   timeout,
  output logic                   irq
);

  logic     rx_done_q;
  logic     overrun_q, overrun_d;
  logic     irq_q, irq_d;
  logic     push, pop_ok, drop;
  irq_src_t irq_src;

  // One push per frame no matter how long rx_done is held.
  assign push   = rx_done & ~rx_done_q;
  assign pop_ok = rd_en & ~empty;
  assign drop   = push & full & ~pop_ok;

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RSTn  (RSTn),
    .push  (push),
    .pop   (rd_en),
    .din   (rx_byte),
    .dout  (rd_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A drop in the same cycle as clr_ovr must not be lost.
  always_comb begin
    overrun_d = overrun_q;
    if (drop)         overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (push | pop_ok | empty | rx_busy)
      tmo_cnt_d = '0;
    else if (tmo_cnt_q != TW'(TIMEOUT_CYC))
      tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout = (tmo_cnt_q == TW'(TIMEOUT_CYC));
`else
  localparam int unsigned unused_tmo_cyc = TIMEOUT_CYC;
  logic unused_busy;
  assign unused_busy = rx_busy;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    irq_src              = '0;
    irq_src[IRQ_THR_BIT] = (thr != '0) && (count >= thr);
    irq_src[IRQ_TMO_BIT] = timeout;
    irq_src[IRQ_OVR_BIT] = overrun_q;
    irq_d                = |irq_src;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_done_q <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a queue-based reference model tracks
// the expected FIFO contents and flags; a negedge monitor compares status
// every cycle and pops expected bytes whenever the DUT performs a read.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          RSTn    = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          rx_done = 1'b0;
  logic          rx_busy = 1'b0;
  logic [CW-1:0] thr     = '0;
  logic          rd_en   = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [7:0]    rd_data;
  logic [CW-1:0] count;
  logic          empty, full, overrun, timeout, irq;

  uart_rx_ctrl #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk     (clk),
    .RSTn    (RSTn),
    .rx_byte (rx_byte),
    .rx_done (rx_done),
    .rx_busy (rx_busy),
    .thr     (thr),
    .rd_en   (rd_en),
    .clr_ovr (clr_ovr),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .overrun (overrun),
    .timeout (timeout),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_q[$];    // bytes held in the FIFO
  logic [7:0] exp_q[$];  // scoreboard: bytes in the order they must be read
  bit         m_prev_done;
  bit         m_ovr;
  bit         m_irq;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  int         m_idle;
`endif

  function automatic bit m_tmo();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    return (m_idle == TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      m_q.delete();
      exp_q.delete();
      m_prev_done = 1'b0;
      m_ovr       = 1'b0;
      m_irq       = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      m_idle      = 0;
`endif
    end else begin
      int n;
      bit push, pop, drop, was_empty;
      n         = m_q.size();
      push      = rx_done && !m_prev_done;
      pop       = rd_en && (n > 0);
      was_empty = (n == 0);
      drop      = push && (n == DEPTH) && !pop;
      // irq reflects the sources as they stood before this edge
      m_irq = ((thr != 0) && (n >= int'(thr))) || m_tmo() || m_ovr;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) begin
        m_q.push_back(rx_byte);
        exp_q.push_back(rx_byte);
      end
      if (drop)         m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      if (push || pop || was_empty || rx_busy) m_idle = 0;
      else if (m_idle < TMO)                   m_idle++;
`else
      if (was_empty) m_irq = m_irq;
`endif
      m_prev_done = rx_done;
    end
  end

  always @(negedge clk) begin
    if (!RSTn) begin
      chk("rst_count",   count,   0);
      chk("rst_empty",   empty,   1);
      chk("rst_full",    full,    0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_irq",     irq,     0);
      chk("rst_rd_data", rd_data, 0);
    end else begin
      chk("count",   count,   m_q.size());
      chk("empty",   empty,   m_q.size() == 0);
      chk("full",    full,    m_q.size() == DEPTH);
      chk("overrun", overrun, m_ovr);
      chk("timeout", timeout, m_tmo());
      chk("irq",     irq,     m_irq);
      chk("head",    rd_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
      if (rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_data actual=%0h expected=none at %0t", rd_data, $time);
        end else begin
          chk("pop_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit d, input logic [7:0] b, input bit busy,
                     input bit rd, input bit clr);
    rx_done = d;
    rx_byte = b;
    rx_busy = busy;
    rd_en   = rd;
    clr_ovr = clr;
    @(posedge clk);
    #1;
  endtask

  // rx_done held for len cycles, then one low cycle; rd/clr apply to the
  // first (push) cycle only.
  task automatic frame(input logic [7:0] b, input int len, input bit rd,
                       input bit clr);
    for (int i = 0; i < len; i++) cyc(1'b1, b, 1'b0, (i == 0) && rd, (i == 0) && clr);
    cyc(1'b0, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, busy, 1'b0, 1'b0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 RSTn = 1'b1;
    idle(2, 1'b0);

    // single frame, long rx_done
    frame(8'hA5, 3, 1'b0, 1'b0);
    idle(2, 1'b0);
    pops(1);
    pops(1);  // pop while empty: no effect
    idle(2, 1'b0);

    // fill and overflow, then drain in order and clear overrun
    for (int i = 1; i <= 9; i++) frame(8'(i), 1, 1'b0, 1'b0);
    idle(2, 1'b0);
    frame(8'hEE, 1, 1'b0, 1'b1);  // drop coinciding with clear: set wins
    idle(1, 1'b0);
    pops(8);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // push and pop together while full
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame(8'h20 + 8'(i), 2, 1'b1, 1'b0);
    pops(8);
    idle(2, 1'b0);

    // threshold
    thr = CW'(4);
    for (int i = 0; i < 3; i++) frame(8'h30 + 8'(i), 1, 1'b0, 1'b0);
    idle(2, 1'b0);
    frame(8'h33, 1, 1'b0, 1'b0);
    idle(2, 1'b0);
    pops(1);
    idle(2, 1'b0);
    pops(3);
    thr = '0;

    // idle timeout, then the same with the receiver busy
    frame(8'h44, 1, 1'b0, 1'b0);
    idle(TMO + 4, 1'b0);
    pops(1);
    idle(2, 1'b0);
    frame(8'h55, 1, 1'b0, 1'b0);
    idle(TMO + 4, 1'b1);
    idle(TMO + 4, 1'b0);
    pops(1);
    idle(2, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int len, gap;
      logic [7:0] b;
      if (i % 50 == 0) thr = CW'($urandom_range(0, DEPTH));
      len = $urandom_range(1, 3);
      gap = $urandom_range(1, 3);
      b   = 8'($urandom);
      for (int j = 0; j < len; j++)
        cyc(1'b1, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 7) == 0));
      for (int j = 0; j < gap; j++)
        cyc(1'b0, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 7) == 0));
    end
    thr = '0;
    pops(DEPTH);

    // reset mid-stream with count = 5
    for (int i = 0; i < 5; i++) frame(8'h60 + 8'(i), 1, 1'b0, 1'b0);
    #2 RSTn = 1'b0;
    repeat (2) @(posedge clk);
    #1 RSTn = 1'b1;
    frame(8'h3C, 1, 1'b0, 1'b0);
    idle(1, 1'b0);
    pops(1);
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller sitting between the UART receiver and the CPU bus interface. It captures each completed byte from the receiver into a small show-ahead FIFO. It raises a level interrupt on fill threshold, idle timeout or overrun, and lets software pop bytes one per strobe. It decouples bus polling latency from the line rate and turns the receiver's multi-cycle "frame done" level into exactly one push per frame.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- TIMEOUT_CYC, 4096: idle `clk` cycles before timeout flag; must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- rx_byte  input  8  receiver data; stable while rx_done high.
- rx_done  input  1  receiver frame-complete level; may stay high several cycles.
- rx_busy  input  1  receiver mid-frame (baud enable).
- thr  input  $clog2(DEPTH)+1  interrupt fill threshold; 0 disables the threshold source.
- rd_en  input  1  pop strobe, one byte per cycle high.
- clr_ovr  input  1  clears the sticky overrun flag.
- rd_data  output  8  FIFO head (show-ahead); 8'h00 when empty.
- count  output  $clog2(DEPTH)+1  current fill level.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overrun  output  1  sticky; a byte was dropped.
- timeout  output  1  idle timeout flag.
- irq  output  1  level interrupt.

## Operation
- Push detect: register rx_done into rx_done_q. Push pulse = rx_done & ~rx_done_q. Exactly one push per rising edge, regardless of how long rx_done stays high.
- Push: write rx_byte to the write pointer slot and advance the pointer, modulo DEPTH.
- Pop: when rd_en & ~empty, advance the read pointer. rd_en while empty is ignored and leaves no side effects.
- count rules:
  - push only: count +1.
  - pop only: count −1.
  - push and pop in the same cycle: unchanged, including when full (both succeed).
- Push while full with no pop: the byte is dropped, pointers are unchanged, and overrun is set.
- overrun clears on clr_ovr. If a new drop and clr_ovr occur in the same cycle, set wins.
- Timeout counter (tmo_cnt, wide enough for TIMEOUT_CYC):
  - Reset to 0 on any push or pop, and whenever empty or rx_busy is high.
  - Otherwise it increments, saturating at TIMEOUT_CYC.
  - timeout = (tmo_cnt == TIMEOUT_CYC).
  - Net effect: timeout is set when the FIFO is non-empty and the line has been idle for TIMEOUT_CYC cycles. It clears on the cycle after the next push or pop, or when the FIFO empties.
- irq = ((thr != 0) & (count >= thr)) | timeout | overrun, registered.

## Timing
- Reset values: count 0, empty 1, full 0, overrun 0, timeout 0, irq 0, rd_data 8'h00, rx_done_q 0, pointers 0.
- Push latency: rx_done rising at edge N → count and empty update after edge N+1. rd_data then shows the byte if the FIFO was empty.
- Pop: rd_data is valid when ~empty. Sample rd_data in the same cycle as rd_en; the next head appears after that edge.
- irq lags its sources by one cycle.
- Wrap-around: pointers wrap silently; full/empty come from count, not pointer compare.
- rx_done already high when RSTn releases: rx_done_q resets to 0, so a push occurs on the first edge. This is accepted behaviour.
- Reset mid-operation clears all state immediately; FIFO contents are discarded and need not be cleared.

## Configuration
- UART_RX_CTRL_TIMEOUT_EN defined: tmo_cnt and the timeout logic are compiled in as described above.
- Not defined: no counter is instantiated, the timeout output is tied 0, and irq = threshold | overrun. TIMEOUT_CYC is unused.

## Structure
- Shared package uart_pkg holds:
  - UART_DATA_W = 8.
  - Default DEPTH and TIMEOUT_CYC.
  - The interrupt-source bit positions (THR=0, TMO=1, OVR=2) for the bus status register.
- One sub-module, uart_rx_fifo, a show-ahead synchronous FIFO with:
  - Inputs: push, pop, din.
  - Outputs: dout, count, full, empty.
- Edge detect, overrun, timeout and irq logic stay in uart_rx_ctrl.

## Test plan
- Single frame: rx_done high 3 cycles with rx_byte 8'hA5 → exactly one push; count=1, rd_data=8'hA5; a pop returns count 0 and rd_data 8'h00.
- Fill and overflow (DEPTH=8): 9 frames 8'h01..8'h09 with no pops → full=1, overrun=1, irq=1; pops return 01..08 in order; clr_ovr clears overrun.
- Simultaneous push+pop while full: count stays 8, overrun stays 0, and order is preserved.
- Threshold: thr=4, push 3 bytes → irq=0; 4th byte → irq=1 one cycle after count=4; one pop → irq=0.
- Timeout (macro on, TIMEOUT_CYC=16): push 1 byte, hold rx_busy=0 → timeout=1 after 16 idle cycles, irq=1. Holding rx_busy=1 instead keeps timeout=0. Macro off → timeout never asserts.
- Reset mid-stream: assert RSTn low with count=5 → all outputs at reset values within the reset assertion; the next frame is the new head.
